// File: rtl/mul_seq_if.sv
// Handshake and result bundle between the RISC240 control path and the
// sequential multiplier.
interface mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [3:0]       ccOut;

    modport master (
        output start, a, b,
        input  busy, done, product, ccOut
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, ccOut
    );
endinterface

// File: rtl/mul_seq.sv
// 16x16 signed shift-add multiplier sequencer: magnitudes are multiplied and the
// sign is applied once at the end. Optional MUL_EARLY_EXIT_EN stops iterating once
// the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add iteration per cycle
// FIX   | apply sign, register product and flags
// DONE  | done pulse; a new start is accepted here
module mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clock,
    input  logic     reset,
    mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplr;
    logic [3:0]           cnt;
    logic                 neg;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     product;
    logic [3:0]           cc;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   res;
    logic                 last_iter;
    logic                 ovf;

    // |-32768| wraps to 0x8000, which is the right magnitude read as unsigned
    always_comb begin
        abs_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
        abs_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;
        acc_next = mplr[0] ? acc + mcand : acc;
        res      = neg ? -acc : acc;
        ovf      = !((&res[2*WIDTH-1:WIDTH-1]) || (~|res[2*WIDTH-1:WIDTH-1]));
`ifdef MUL_EARLY_EXIT_EN
        last_iter = (cnt == 4'd15) || (mplr[WIDTH-1:1] == '0);
`else
        last_iter = (cnt == 4'd15);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplr    <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cc      <= 4'b0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        mcand <= {{WIDTH{1'b0}}, abs_a};
                        mplr  <= abs_b;
                        neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 4'd1;
                    if (last_iter) state <= FIX;
                end
                FIX: begin
                    product <= res[WIDTH-1:0];
                    // {Z,C,N,V}
                    cc      <= {(res[WIDTH-1:0] == '0), 1'b0, res[WIDTH-1], ovf};
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
    assign bus.ccOut   = cc;
endmodule
